sat_div_16: RTL and testbench
=============================

SAT_DIV_16 -- requirements
Module: sat_div_16

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width in bits; only 16 is required to work.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port: A  input  16  signed two's-complement dividend.
REQ-006 SHALL have port: B  input  16  signed two's-complement divisor.
REQ-007 SHALL have port: Quot  output  16  signed quotient, registered.
REQ-008 SHALL have port: Rem  output  16  signed remainder, registered.
REQ-009 SHALL have port: Ovfl  output  1  quotient saturated (0x8000 / 0xFFFF case).
REQ-010 SHALL have port: DivZero  output  1  divisor was zero, quotient saturated.
REQ-011 SHALL have port: busy  output  1  high while not in IDLE.
REQ-012 SHALL have port: done  output  1  one-cycle pulse, results valid.

Function
REQ-013 SHALL implement states IDLE, CALC, DONE; CALC iterates once per clock.
REQ-014 In IDLE with start=1 at edge N, SHALL latch A and B, clear Ovfl/DivZero and enter CALC, or enter DONE directly for the special cases.
REQ-015 SHALL divide sign-magnitude: restoring shift-subtract on |A| and |B| (17-bit partial remainder), one quotient bit per CALC cycle, MSB first, WIDTH iterations.
REQ-016 After the WIDTH-th CALC cycle, SHALL enter DONE; done high for exactly the cycle after edge N+17; Quot/Rem/flags update on that same edge.
REQ-017 Quotient SHALL truncate toward zero; negate if sign(A) XOR sign(B); remainder sign SHALL equal sign(A); a zero remainder stays 0x0000.
REQ-018 |0x8000| SHALL be handled as unsigned 0x8000 without overflow of the magnitude path.
REQ-019 B=0x0000: SHALL skip CALC; DONE after edge N+1; Quot=0x7FFF if A>=0 else 0x8000; Rem=A; DivZero=1; Ovfl=0.
REQ-020 A=0x8000 and B=0xFFFF: SHALL skip CALC; DONE after edge N+1; Quot=0x7FFF; Rem=0x0000; Ovfl=1; DivZero=0.
REQ-021 DONE SHALL return to IDLE on the next edge unconditionally; done is never high two consecutive cycles.
REQ-022 Quot, Rem, Ovfl, DivZero SHALL hold their value from DONE until the next DONE or reset.
REQ-023 start while busy=1 SHALL be ignored, including start in DONE; A/B changes during CALC SHALL not affect the result.
REQ-024 start asserted in the IDLE cycle immediately after DONE SHALL be accepted (back-to-back throughput 18 cycles).
REQ-025 busy SHALL be combinationally derived from state (high in CALC and DONE).

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, iteration counter 0, Quot=0x0000, Rem=0x0000, Ovfl=0, DivZero=0, done=0, busy=0.
REQ-027 rst SHALL take priority over start and over any in-progress division; an aborted division SHALL never produce done.
REQ-028 start sampled in the same cycle as rst=1 SHALL be discarded.

Verification
REQ-029 A=100 (0x0064), B=7, start at edge N -> done after edge N+17; Quot=0x000E, Rem=0x0002, Ovfl=0, DivZero=0.
REQ-030 A=-100 (0xFF9C), B=7 -> Quot=0xFFF2 (-14), Rem=0xFFFE (-2); A=100, B=-7 -> Quot=0xFFF2, Rem=0x0002.
REQ-031 A=0x8000, B=0xFFFF -> done after edge N+1; Quot=0x7FFF, Rem=0x0000, Ovfl=1; A=0x8000, B=0x0001 -> Quot=0x8000, Ovfl=0 after 17 edges.
REQ-032 A=5, B=0 -> Quot=0x7FFF, Rem=0x0005, DivZero=1; A=-5 (0xFFFB), B=0 -> Quot=0x8000, Rem=0xFFFB, DivZero=1.
REQ-033 Start 100/7, assert rst for one cycle at edge N+8 -> busy=0, all outputs 0 next cycle, no done pulse; a fresh 100/7 afterwards completes correctly.
REQ-034 Start 100/7, pulse start with A=1, B=1 at N+5 and in DONE -> ignored; result 14/2; start held high continuously -> new division accepted every 18 cycles.

Source files
------------

// File: rtl/sat_div_16.sv
// sat_div_16: sequential signed 16-bit divider with saturation.
// Sign-magnitude restoring shift-subtract, one quotient bit per clock.
// Divide-by-zero and the 0x8000 / -1 overflow case bypass the iteration.
module sat_div_16 #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Quot,
   output logic [WIDTH-1:0] Rem,
   output logic             Ovfl,
   output logic             DivZero,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [WIDTH-1:0] POS_MAX  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] NEG_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [CW-1:0]    LAST_IT  = CW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [WIDTH-1:0] a_q,     a_d;      // raw dividend: sign and divide-by-zero remainder
   logic             b_neg_q, b_neg_d;
   logic [WIDTH-1:0] dvd_q,   dvd_d;    // |A| shifting out, quotient bits shifting in
   logic [WIDTH-1:0] dsr_q,   dsr_d;    // |B|
   logic [WIDTH-1:0] prem_q,  prem_d;   // partial remainder (always < |B|)
   logic             dz_q,    dz_d;
   logic             ov_q,    ov_d;
   logic [WIDTH-1:0] quot_q,  quot_d;
   logic [WIDTH-1:0] rem_q,   rem_d;
   logic             ovfl_q,  ovfl_d;
   logic             divz_q,  divz_d;
   logic             done_q,  done_d;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic [WIDTH-1:0] quot_norm;
   logic [WIDTH-1:0] rem_norm;

   // Next-state, datapath iteration and result formatting
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_neg_d = b_neg_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      prem_d  = prem_q;
      dz_d    = dz_q;
      ov_d    = ov_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      ovfl_d  = ovfl_q;
      divz_d  = divz_q;
      done_d  = 1'b0;

      // 0x8000 negates to itself, which is the correct unsigned magnitude
      a_mag = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
      b_mag = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;

      // Partial remainder < |B| <= 2^(WIDTH-1), so the top diff bit is a clean borrow
      rem_sh = {prem_q, dvd_q[WIDTH-1]};
      diff   = rem_sh - {1'b0, dsr_q};
      ge     = ~diff[WIDTH];

      quot_norm = (a_q[WIDTH-1] ^ b_neg_q) ? (~dvd_q + WIDTH'(1)) : dvd_q;
      rem_norm  = a_q[WIDTH-1] ? (~prem_q + WIDTH'(1)) : prem_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               b_neg_d = B[WIDTH-1];
               dvd_d   = a_mag;
               dsr_d   = b_mag;
               prem_d  = '0;
               cnt_d   = '0;
               dz_d    = 1'b0;
               ov_d    = 1'b0;
               if (B == '0) begin
                  dz_d    = 1'b1;
                  state_d = S_DONE;
               end else if ((A == NEG_MIN) && (B == ALL_ONES)) begin
                  ov_d    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            prem_d = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            dvd_d  = {dvd_q[WIDTH-2:0], ge};
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST_IT) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            ovfl_d  = ov_q;
            divz_d  = dz_q;
            if (dz_q) begin
               quot_d = a_q[WIDTH-1] ? NEG_MIN : POS_MAX;
               rem_d  = a_q;
            end else if (ov_q) begin
               quot_d = POS_MAX;
               rem_d  = '0;
            end else begin
               quot_d = quot_norm;
               rem_d  = rem_norm;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_neg_q <= 1'b0;
         dvd_q   <= '0;
         dsr_q   <= '0;
         prem_q  <= '0;
         dz_q    <= 1'b0;
         ov_q    <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         ovfl_q  <= 1'b0;
         divz_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_neg_q <= b_neg_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         prem_q  <= prem_d;
         dz_q    <= dz_d;
         ov_q    <= ov_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         ovfl_q  <= ovfl_d;
         divz_q  <= divz_d;
         done_q  <= done_d;
      end
   end

   // Output mapping; busy follows the state directly
   always_comb begin
      Quot    = quot_q;
      Rem     = rem_q;
      Ovfl    = ovfl_q;
      DivZero = divz_q;
      done    = done_q;
      busy    = (state_q != S_IDLE);
   end

endmodule

// File: tb/tb_sat_div_16.sv
// tb_sat_div_16: table-driven checks of sat_div_16 plus reset/abort,
// ignored-start and back-to-back sequences.
module tb_sat_div_16;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] a_i;
   logic [15:0] b_i;
   logic [15:0] quot;
   logic [15:0] rem;
   logic        ovfl;
   logic        divzero;
   logic        busy;
   logic        done;

   int n_pass;
   int n_total;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        ov;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t vecs[17];

   sat_div_16 #(.WIDTH(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .A       (a_i),
      .B       (b_i),
      .Quot    (quot),
      .Rem     (rem),
      .Ovfl    (ovfl),
      .DivZero (divzero),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Issue one division and return the number of edges from the start edge to done
   task automatic run_div(input logic [15:0] a, input logic [15:0] b, output int lat);
      @(negedge clk);
      a_i   = a;
      b_i   = b;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic check_done_drops();
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
   endtask

   initial begin
      int lat;
      int pulses;
      int first_k;
      int prev_k;
      logic prev_done;

      n_pass  = 0;
      n_total = 0;

      //           a        b        q        r        ov    dz    lat
      vecs[0]  = '{16'h0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 1'b0, 17};
      vecs[1]  = '{16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17};
      vecs[2]  = '{16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0, 17};
      vecs[3]  = '{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 1'b0, 17};
      vecs[4]  = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 1};
      vecs[5]  = '{16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 17};
      vecs[6]  = '{16'h0005, 16'h0000, 16'h7FFF, 16'h0005, 1'b0, 1'b1, 1};
      vecs[7]  = '{16'hFFFB, 16'h0000, 16'h8000, 16'hFFFB, 1'b0, 1'b1, 1};
      vecs[8]  = '{16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 17};
      vecs[9]  = '{16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 17};
      vecs[10] = '{16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b0, 1'b0, 17};
      vecs[11] = '{16'hFFFD, 16'h0007, 16'h0000, 16'hFFFD, 1'b0, 1'b0, 17};
      vecs[12] = '{16'h8000, 16'hFFFE, 16'h4000, 16'h0000, 1'b0, 1'b0, 17};
      vecs[13] = '{16'h8000, 16'h0003, 16'hD556, 16'hFFFE, 1'b0, 1'b0, 17};
      vecs[14] = '{16'h04D2, 16'h8000, 16'h0000, 16'h04D2, 1'b0, 1'b0, 17};
      vecs[15] = '{16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 17};
      vecs[16] = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};

      rst   = 1'b1;
      start = 1'b0;
      a_i   = '0;
      b_i   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_quot", 32'(quot), 32'h0);
      check("rst_rem", 32'(rem), 32'h0);
      check("rst_ovfl", 32'(ovfl), 32'd0);
      check("rst_divzero", 32'(divzero), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         run_div(vecs[i].a, vecs[i].b, lat);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         check($sformatf("v%0d_quot", i), 32'(quot), 32'(vecs[i].q));
         check($sformatf("v%0d_rem", i), 32'(rem), 32'(vecs[i].r));
         check($sformatf("v%0d_ovfl", i), 32'(ovfl), 32'(vecs[i].ov));
         check($sformatf("v%0d_divzero", i), 32'(divzero), 32'(vecs[i].dz));
         check_done_drops();
         check($sformatf("v%0d_quot_hold", i), 32'(quot), 32'(vecs[i].q));
      end

      // Abort 100/7 with reset at start edge + 8
      @(negedge clk);
      a_i = 16'd100; b_i = 16'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_quot", 32'(quot), 32'h0);
      check("abort_rem", 32'(rem), 32'h0);
      check("abort_ovfl", 32'(ovfl), 32'd0);
      check("abort_divzero", 32'(divzero), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int k = 0; k < 30; k++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check("abort_no_done", 32'(pulses), 32'd0);

      // start together with rst is discarded
      @(negedge clk);
      rst = 1'b1; start = 1'b1; a_i = 16'd100; b_i = 16'd7;
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      check("rst_start_discard", 32'(busy), 32'd0);

      run_div(16'd100, 16'd7, lat);
      check("fresh_latency", 32'(lat), 32'd17);
      check("fresh_quot", 32'(quot), 32'h000E);
      check("fresh_rem", 32'(rem), 32'h0002);
      check_done_drops();

      // Spurious starts during CALC and DONE, with operands changed mid-division
      @(negedge clk);
      a_i = 16'd100; b_i = 16'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      first_k = -1;
      pulses  = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 5 || k == 17) begin
            start = 1'b1; a_i = 16'd1; b_i = 16'd1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done) begin
            pulses++;
            if (first_k < 0) begin
               first_k = k;
               check("ign_quot", 32'(quot), 32'h000E);
               check("ign_rem", 32'(rem), 32'h0002);
            end
         end
      end
      check("ign_latency", 32'(first_k), 32'd17);
      check("ign_pulses", 32'(pulses), 32'd1);
      check("ign_idle", 32'(busy), 32'd0);

      // start held high: new division every 18 cycles
      @(negedge clk);
      a_i = 16'd100; b_i = 16'd7; start = 1'b1;
      pulses    = 0;
      first_k   = -1;
      prev_k    = -1;
      prev_done = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         if (done) begin
            if (prev_done) check("b2b_done_twice", 32'd1, 32'd0);
            if (first_k < 0) first_k = k;
            else check($sformatf("b2b_interval_%0d", pulses), 32'(k - prev_k), 32'd18);
            check($sformatf("b2b_quot_%0d", pulses), 32'(quot), 32'h000E);
            prev_k = k;
            pulses++;
         end
         prev_done = done;
      end
      @(negedge clk);
      start = 1'b0;
      check("b2b_first", 32'(first_k), 32'd17);
      check("b2b_pulses", 32'(pulses), 32'd3);
      repeat (25) @(posedge clk);
      #1;
      check("b2b_drain", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
